resistor_capacitor_low_pass_filter: RTL

- Discrete-audio RC low-pass stage, the complement of the team's RC high-pass filter.
- Per audio sample it integrates y += alpha·(x − y) over OVERSAMPLE sub-steps using one shared multiplier sequenced by a small FSM.
- Sits in the analog-model chain between sound generators and the mixer; runs on the system clock, gated by the audio_clk_en strobe.

---
 rtl/discrete_filter_pkg.sv | 45 ++++
 rtl/resistor_capacitor_low_pass_filter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/discrete_filter_pkg.sv
// Shared fixed-point definitions for the discrete RC filter stages.
// Holds the Q16.16 widths, the filter FSM state type, the elaboration-time
// alpha calculation, and the 16-bit output saturation helper.
package discrete_filter_pkg;

    localparam int SAMPLE_W = 16;
    localparam int STATE_W  = 32;
    localparam int FRAC_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_DONE
    } filter_state_t;

    // alpha = dt / (RC + dt) in Q0.16, where dt is one oversampled sub-step.
    // Both dt and RC are expressed in seconds scaled by 2^32.
    function automatic logic [16:0] rc_alpha_16(
        input longint r,
        input longint c_35_shifted,
        input longint sample_rate,
        input longint oversample
    );
        longint dt_sub_32;
        longint rc_32;
        longint alpha;
        dt_sub_32 = ((longint'(1) <<< 32) / sample_rate) / oversample;
        rc_32     = (r * c_35_shifted) >>> 3;
        alpha     = (dt_sub_32 <<< 16) / (rc_32 + dt_sub_32);
        return alpha[16:0];
    endfunction

    // Clamp a 33-bit signed integer part to the 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] saturate16(
        input logic signed [STATE_W:0] v
    );
        if (v > 33'sd32767)
            return 16'sd32767;
        else if (v < -33'sd32768)
            return -16'sd32768;
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/resistor_capacitor_low_pass_filter.sv
// RC low-pass stage: per audio strobe, integrates y += alpha*(x - y) over
// OVERSAMPLE sub-steps with one shared multiplier, then publishes the
// saturated integer part of y with a one-cycle out_valid pulse.
// Optional build macro RC_LOW_PASS_FILTER_ROUNDING_EN selects round-half-up
// in both the step product and the output conversion (default: truncation).
module resistor_capacitor_low_pass_filter
    import discrete_filter_pkg::*;
#(
    parameter int CLOCK_RATE   = 50000000,
    parameter int SAMPLE_RATE  = 48000,
    parameter int R            = 10000,
    parameter int C_35_SHIFTED = 3436,
    parameter int OVERSAMPLE   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       audio_clk_en,
    input  logic signed [SAMPLE_W-1:0] in,
    output logic signed [SAMPLE_W-1:0] out,
    output logic                       out_valid,
    output logic                       overrun
);

    localparam logic [16:0] ALPHA_16 = rc_alpha_16(R, C_35_SHIFTED, SAMPLE_RATE, OVERSAMPLE);
    localparam int PROD_W = STATE_W + 1 + 18;
    localparam int STEP_W = 5;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OVERSAMPLE - 1);

`ifdef RC_LOW_PASS_FILTER_ROUNDING_EN
    localparam logic signed [PROD_W-1:0]  STEP_BIAS = PROD_W'(1 << (FRAC_W - 1));
    localparam logic signed [STATE_W:0]   OUT_BIAS  = 33'sd32768;
`else
    localparam logic signed [PROD_W-1:0]  STEP_BIAS = '0;
    localparam logic signed [STATE_W:0]   OUT_BIAS  = '0;
`endif

    // Reject configurations the sequencing cannot honour.
    if (OVERSAMPLE < 1 || OVERSAMPLE > 16) begin : g_bad_oversample
        $error("OVERSAMPLE must be within 1..16");
    end
    if (CLOCK_RATE / SAMPLE_RATE < OVERSAMPLE + 2) begin : g_bad_rate
        $error("clock too slow for OVERSAMPLE+2 cycles per sample");
    end

    filter_state_t               state_reg, state_next;
    logic signed [SAMPLE_W-1:0]  x_reg;
    logic signed [STATE_W-1:0]   y_reg;
    logic [STEP_W-1:0]           step_reg;

    logic                        load_x;
    logic                        do_step;
    logic                        emit;
    logic                        busy_strobe;

    logic signed [STATE_W-1:0]   x_shift;
    logic signed [STATE_W:0]     diff;
    logic signed [PROD_W-1:0]    prod;
    logic signed [STATE_W-1:0]   p_step;
    logic signed [STATE_W-1:0]   y_stepped;
    logic signed [STATE_W:0]     y_wide;
    logic signed [STATE_W:0]     y_int;
    logic signed [SAMPLE_W-1:0]  out_value;

    // Shared MAC: one alpha multiply per cycle, plus the output conversion.
    always_comb begin
        x_shift   = {x_reg, {FRAC_W{1'b0}}};
        diff      = {x_shift[STATE_W-1], x_shift} - {y_reg[STATE_W-1], y_reg};
        prod      = diff * $signed({1'b0, ALPHA_16});
        p_step    = STATE_W'((prod + STEP_BIAS) >>> FRAC_W);
        y_stepped = y_reg + p_step;
        y_wide    = {y_reg[STATE_W-1], y_reg};
        y_int     = (y_wide + OUT_BIAS) >>> FRAC_W;
        out_value = saturate16(y_int);
    end

    // Sequencer: a strobe always wins and restarts the sub-step run.
    always_comb begin
        state_next  = state_reg;
        load_x      = 1'b0;
        do_step     = 1'b0;
        emit        = 1'b0;
        busy_strobe = audio_clk_en && (state_reg != ST_IDLE);
        unique case (state_reg)
            ST_IDLE: begin
                if (audio_clk_en) begin
                    load_x     = 1'b1;
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                if (audio_clk_en) begin
                    load_x = 1'b1;
                end else begin
                    do_step = 1'b1;
                    if (step_reg == LAST_STEP)
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (audio_clk_en) begin
                    load_x     = 1'b1;
                    state_next = ST_STEP;
                end else begin
                    emit       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state and integrator registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load_x) begin
                x_reg    <= in;
                step_reg <= '0;
            end else if (do_step) begin
                y_reg    <= y_stepped;
                step_reg <= step_reg + STEP_W'(1);
            end
        end
    end

    // Published sample, its valid pulse and the sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit)
                out <= out_value;
            if (busy_strobe)
                overrun <= 1'b1;
        end
    end

endmodule
